// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder that turns command/address/data byte frames into single-cycle register-bus
// reads and writes. SCK, CSB and SDI are oversampled in the core clock domain.
module spi_reg_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       spi_sck,
  input  logic       spi_csb,
  input  logic       spi_sdi,
  output logic       spi_sdo,
  output logic       spi_sdo_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StDone} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, csb_sync_q, sdi_sync_q;
  logic sck_prev_q, csb_prev_q;
  logic sck_s, csb_s, sdi_s, sck_rise, sck_fall, csb_fall;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_q, rx_d;
  logic        wr_q, wr_d, rd_q, rd_d, stream_q, stream_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d, wdata_q, wdata_d;
  logic        we_q, we_d, re_q, re_d, re_dly_q;
  logic        inc_pend_q, inc_pend_d, load_pend_q, load_pend_d;
  logic [7:0]  buf_q, buf_d, shift_q, shift_d;
  logic        oe_q, oe_d;
  logic [7:0]  byte_in;
  logic        active, byte_done;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign csb_s    = csb_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign csb_fall = ~csb_s & csb_prev_q;

  assign byte_in   = {rx_q, sdi_s};
  assign active    = (state_q == StCmd) || (state_q == StAddr) || (state_q == StData);
  assign byte_done = active && sck_rise && (bit_cnt_q == 3'd7);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    stream_d    = stream_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    inc_pend_d  = 1'b0;
    load_pend_d = load_pend_q;
    buf_d       = re_dly_q ? reg_rdata : buf_q;
    shift_d     = shift_q;
    oe_d        = oe_q;

    // Deferred increment after a write so the following prefetch lands one clock after reg_we.
    if (inc_pend_q) begin
      addr_d = addr_q + 8'd1;
      re_d   = rd_q;
    end

    if (csb_s) begin
      state_d     = StIdle;
      bit_cnt_d   = 3'd0;
      load_pend_d = 1'b0;
      shift_d     = 8'h00;
      oe_d        = 1'b0;
      re_d        = 1'b0;
    end else begin
      if (active && sck_rise) begin
        rx_d      = byte_in[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (csb_fall) begin
            state_d   = StCmd;
            bit_cnt_d = 3'd0;
          end
        end
        StCmd: begin
          if (byte_done) begin
            wr_d     = byte_in[7];
            rd_d     = byte_in[6];
            cnt_d    = byte_in[5:3];
            stream_d = (byte_in[5:3] == 3'd0);
            state_d  = (byte_in[7] || byte_in[6]) ? StAddr : StDone;
          end
        end
        StAddr: begin
          if (byte_done) begin
            addr_d      = byte_in;
            re_d        = rd_q;
            load_pend_d = rd_q;
            state_d     = StData;
          end
        end
        StData: begin
          if (byte_done) begin
            if (wr_q) begin
              we_d       = 1'b1;
              wdata_d    = byte_in;
              inc_pend_d = 1'b1;
            end else begin
              addr_d = addr_q + 8'd1;
              re_d   = rd_q;
            end
            load_pend_d = rd_q;
            if (!stream_q) begin
              cnt_d = cnt_q - 3'd1;
              if (cnt_q == 3'd1) begin
                state_d     = StDone;
                load_pend_d = 1'b0;
                shift_d     = 8'h00;
                oe_d        = 1'b0;
              end
            end
          end else if (sck_fall && rd_q) begin
            if (load_pend_q) begin
              shift_d     = buf_q;
              oe_d        = 1'b1;
              load_pend_d = 1'b0;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
        end
        StDone: begin
          shift_d = 8'h00;
          oe_d    = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      sck_sync_q  <= '0;
      // CSB chain clears low so a transaction already in flight never looks like a fresh start.
      csb_sync_q  <= '0;
      sdi_sync_q  <= '0;
      sck_prev_q  <= 1'b0;
      csb_prev_q  <= 1'b0;
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      stream_q    <= 1'b0;
      cnt_q       <= 3'd0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      re_dly_q    <= 1'b0;
      inc_pend_q  <= 1'b0;
      load_pend_q <= 1'b0;
      buf_q       <= 8'h00;
      shift_q     <= 8'h00;
      oe_q        <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], spi_csb};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
      sck_prev_q  <= sck_s;
      csb_prev_q  <= csb_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      stream_q    <= stream_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
      re_dly_q    <= re_q;
      inc_pend_q  <= inc_pend_d;
      load_pend_q <= load_pend_d;
      buf_q       <= buf_d;
      shift_q     <= shift_d;
      oe_q        <= oe_d;
    end
  end

  assign spi_sdo    = shift_q[7];
  assign spi_sdo_oe = oe_q;
  assign reg_addr   = addr_q;
  assign reg_wdata  = wdata_q;
  assign reg_we     = we_q;
  assign reg_re     = re_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_spi_reg_responder.sv
// Scoreboard bench for spi_reg_responder: directed SPI frames, bus strobes and SDO bytes checked
// by independent monitors against hand-computed expectations.
module tb_spi_reg_responder;

  localparam int H = 8;  // SCK half period in core clocks

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_csb = 1'b1;
  logic       spi_sdi = 1'b0;
  logic       spi_sdo, spi_sdo_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;

  spi_reg_responder #(.SYNC_STAGES(2)) dut (
    .clock      (clock),
    .resetb     (resetb),
    .spi_sck    (spi_sck),
    .spi_csb    (spi_csb),
    .spi_sdi    (spi_sdi),
    .spi_sdo    (spi_sdo),
    .spi_sdo_oe (spi_sdo_oe),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_rdata  (reg_rdata),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       is_we;
    logic [7:0] addr;
    logic [7:0] data;
    logic       after_we;
  } ev_t;

  ev_t        exp_bus[$];
  logic [7:0] exp_sdo[$];
  logic [7:0] mem [256];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_we_cyc = -100;

  always @(posedge clock) begin
    cyc++;
    if (reg_re) reg_rdata <= mem[reg_addr];
  end

  // Bus strobe monitor
  always @(negedge clock) begin
    ev_t e;
    if (reg_we || reg_re) begin
      checks++;
      if (reg_we && reg_re) begin
        failures++;
        $display("FAIL bus_both_strobes addr=%02h got we=1 re=1, need one at a time", reg_addr);
      end else if (exp_bus.size() == 0) begin
        failures++;
        $display("FAIL bus_unexpected got we=%0b re=%0b addr=%02h wdata=%02h, need no strobe",
                 reg_we, reg_re, reg_addr, reg_wdata);
      end else begin
        e = exp_bus.pop_front();
        if (e.is_we != reg_we || e.addr != reg_addr || (reg_we && e.data != reg_wdata) ||
            (e.after_we && cyc != last_we_cyc + 1)) begin
          failures++;
          $display("FAIL bus_event got we=%0b addr=%02h wdata=%02h dcyc=%0d, need we=%0b addr=%02h wdata=%02h after_we=%0b",
                   reg_we, reg_addr, reg_wdata, cyc - last_we_cyc, e.is_we, e.addr, e.data,
                   e.after_we);
        end
      end
      if (reg_we) last_we_cyc = cyc;
    end
  end

  // SDO monitor: master samples on each SCK rise while the pad is enabled
  int sbit = 0;
  logic [7:0] sbyte = 8'h00;
  always @(posedge spi_sck or posedge spi_csb) begin
    logic [7:0] e;
    if (spi_csb) begin
      sbit = 0;
    end else if (spi_sdo_oe) begin
      sbyte = {sbyte[6:0], spi_sdo};
      sbit++;
      if (sbit == 8) begin
        sbit = 0;
        checks++;
        if (exp_sdo.size() == 0) begin
          failures++;
          $display("FAIL sdo_unexpected got %02h, need no read byte", sbyte);
        end else begin
          e = exp_sdo.pop_front();
          if (e != sbyte) begin
            failures++;
            $display("FAIL sdo_byte got %02h, need %02h", sbyte, e);
          end
        end
      end
    end
  end

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %0h, need %0h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic we, input logic [7:0] a, input logic [7:0] d,
                          input logic aw);
    ev_t e;
    e.is_we = we; e.addr = a; e.data = d; e.after_we = aw;
    exp_bus.push_back(e);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic spi_bit(input logic b);
    spi_sdi = b;
    wait_clk(H);
    spi_sck = 1'b1;
    wait_clk(H);
    spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_low();
    spi_csb = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_high();
    wait_clk(H);
    spi_csb = 1'b1;
    wait_clk(2 * H);
  endtask

  task automatic check_outs_zero(input string name);
    check1(name, {12'h0, spi_sdo, spi_sdo_oe, reg_we, reg_re, busy, reg_addr, reg_wdata}, 32'h0);
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[1] = 8'h04; mem[2] = 8'h56; mem[3] = 8'h20;
    mem[8'hFF] = 8'h12; mem[0] = 8'h34;
    wait_clk(4);
    resetb = 1'b1;
    wait_clk(4);
    check_outs_zero("reset_outputs");

    // Single write, no reads
    push_bus(1'b1, 8'h0B, 8'h01, 1'b0);
    cs_low();
    check1("busy_after_csb_low", busy, 1);
    spi_byte(8'h80); spi_byte(8'h0B); spi_byte(8'h01);
    check1("write_oe_low", spi_sdo_oe, 0);
    cs_high();
    check1("busy_after_csb_high", busy, 0);

    // Read stream from address 0 (mem[0] temporarily 0x00)
    mem[0] = 8'h00;
    for (int a = 0; a <= 4; a++) push_bus(1'b0, a[7:0], 8'h00, 1'b0);
    exp_sdo.push_back(8'h00); exp_sdo.push_back(8'h04);
    exp_sdo.push_back(8'h56); exp_sdo.push_back(8'h20);
    cs_low();
    spi_byte(8'h40);
    check1("read_oe_in_cmd", spi_sdo_oe, 0);
    spi_byte(8'h00);
    wait_clk(4);
    check1("read_oe_in_data", spi_sdo_oe, 1);
    for (int i = 0; i < 4; i++) spi_byte(8'h00);
    cs_high();
    check1("read_oe_after_csb", spi_sdo_oe, 0);

    // Fixed length n=1: second data byte ignored
    push_bus(1'b1, 8'h10, 8'hAA, 1'b0);
    cs_low();
    spi_byte(8'h88); spi_byte(8'h10); spi_byte(8'hAA); spi_byte(8'hBB);
    check1("fixed_sdo_zero", spi_sdo, 0);
    check1("fixed_oe_zero", spi_sdo_oe, 0);
    check1("fixed_busy_in_done", busy, 1);
    cs_high();

    // Read/write with address wrap
    mem[0] = 8'h34;
    push_bus(1'b0, 8'hFF, 8'h00, 1'b0);
    push_bus(1'b1, 8'hFF, 8'h5A, 1'b0);
    push_bus(1'b0, 8'h00, 8'h00, 1'b1);
    push_bus(1'b1, 8'h00, 8'hA5, 1'b0);
    push_bus(1'b0, 8'h01, 8'h00, 1'b1);
    exp_sdo.push_back(8'h12); exp_sdo.push_back(8'h34);
    cs_low();
    spi_byte(8'hC0); spi_byte(8'hFF); spi_byte(8'h5A); spi_byte(8'hA5);
    cs_high();

    // Abort on partial byte, then a normal write
    cs_low();
    spi_byte(8'h80); spi_byte(8'h20);
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b0);
    cs_high();
    check1("abort_no_strobe_pending", exp_bus.size(), 0);
    push_bus(1'b1, 8'h21, 8'h77, 1'b0);
    cs_low();
    spi_byte(8'h80); spi_byte(8'h21); spi_byte(8'h77);
    cs_high();

    // Reset during data bit 3 of a read
    push_bus(1'b0, 8'h02, 8'h00, 1'b0);
    cs_low();
    spi_byte(8'h40); spi_byte(8'h02);
    spi_bit(1'b0); spi_bit(1'b0); spi_bit(1'b0);
    spi_sdi = 1'b0;
    wait_clk(H);
    spi_sck = 1'b1;
    wait_clk(2);
    resetb = 1'b0;
    wait_clk(2);
    check_outs_zero("reset_mid_outputs");
    resetb = 1'b1;
    wait_clk(H - 4);
    spi_sck = 1'b0;
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    spi_byte(8'h80); spi_byte(8'h30);
    check1("reset_mid_busy", busy, 0);
    cs_high();
    push_bus(1'b1, 8'h30, 8'h99, 1'b0);
    cs_low();
    spi_byte(8'h80); spi_byte(8'h30); spi_byte(8'h99);
    cs_high();

    wait_clk(10);
    check1("bus_queue_drained", exp_bus.size(), 0);
    check1("sdo_queue_drained", exp_sdo.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
